ex_result_stage: RTL and testbench

- Execute-to-memory pipeline stage directly downstream of the combinational ALU.
- Registers the ALU result, destination register and write-enable, and presents them to the MEM stage over a valid/ready handshake.
- A 2-entry skid buffer sustains one transfer per cycle under backpressure.
- Owns the architectural N/Z/V flag register; flags update in program order as results are accepted.

---
 rtl/ex_result_stage_pkg.sv | 41 ++++
 rtl/ex_skid_buf.sv | 98 +++++++++
 rtl/ex_result_stage.sv | 95 +++++++++
 tb/tb_ex_result_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_result_stage_pkg.sv
// ex_result_stage_pkg
// Shared definitions for the EX result stage and its neighbours.
//   - opcode constants for the ALU instruction set
//   - packed pipeline entry {data, rd, wb_en, opcode} used by ALU, EX and MEM
//   - skid buffer occupancy encoding
//   - is_alu_op(): true for opcodes the ALU actually drives a result for
package ex_result_stage_pkg;

    localparam int EX_DATA_W = 32;
    localparam int EX_REG_W  = 5;
    localparam int EX_OP_W   = 6;

    localparam logic [EX_OP_W-1:0] OP_ADD   = 6'h20;
    localparam logic [EX_OP_W-1:0] OP_ADDI  = 6'h21;
    localparam logic [EX_OP_W-1:0] OP_SUB   = 6'h22;
    localparam logic [EX_OP_W-1:0] OP_NAND  = 6'h23;
    localparam logic [EX_OP_W-1:0] OP_AND   = 6'h24;
    localparam logic [EX_OP_W-1:0] OP_ANDI  = 6'h25;
    localparam logic [EX_OP_W-1:0] OP_SRL   = 6'h26;
    localparam logic [EX_OP_W-1:0] OP_SLL   = 6'h27;
    localparam logic [EX_OP_W-1:0] OP_XOR   = 6'h28;
    localparam logic [EX_OP_W-1:0] OP_NO_OP = 6'h3F;

    typedef struct packed {
        logic [EX_DATA_W-1:0] data;
        logic [EX_REG_W-1:0]  rd;
        logic                 wb_en;
        logic [EX_OP_W-1:0]   opcode;
    } ex_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic logic is_alu_op(input logic [EX_OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// ex_skid_buf
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready depends only on registered state, so the upstream ready path is
// cut; one transfer per cycle is sustained while out_ready stays high.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   BUF_EMPTY | no entry held; out_valid=0
//   BUF_ONE   | main slot valid; can still take one more entry
//   BUF_FULL  | main and skid valid (skid younger); in_ready=0
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               drop every held entry at the next edge
//   in_valid/in_ready   upstream handshake, in_data is the entry
//   out_valid/out_ready downstream handshake, out_data is the oldest entry
module ex_skid_buf
    import ex_result_stage_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         push;
    logic         load_main, load_skid, skid_to_main;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BUF_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        load_main = 1'b1;
                        state_d   = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && out_ready) begin
                        load_main = 1'b1;
                    end else if (push) begin
                        load_skid = 1'b1;
                        state_d   = BUF_FULL;
                    end else if (out_ready) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (out_ready) begin
                        skid_to_main = 1'b1;
                        state_d      = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    // Payload registers hold their value when not loaded, which keeps out_data
    // stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else begin
            if (load_main)    main_q <= in_data;
            if (skid_to_main) main_q <= skid_q;
            if (load_skid)    skid_q <= in_data;
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage
// EX->MEM pipeline stage behind the combinational ALU. Filters opcodes,
// buffers results in a 2-entry skid buffer and owns the N/Z/V flags.
//
// Ports:
//   clk, rst_n, flush                  clock, async reset, sync kill
//   in_valid/in_ready                  EX handshake (in_ready registered)
//   alu_out, alu_n/z/v, alu_done       ALU result and flags
//   opcode, rd, wb_en                  instruction fields from EX
//   out_valid/out_ready                MEM handshake
//   out_data/out_rd/out_wb_en/out_opcode buffered entry
//   flag_n/flag_z/flag_v               architectural flags
module ex_result_stage
    import ex_result_stage_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int REG_W  = EX_REG_W,
    parameter int OP_W   = EX_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_done,
    input  logic [OP_W-1:0]   opcode,
    input  logic [REG_W-1:0]  rd,
    input  logic              wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wb_en,
    output logic [OP_W-1:0]   out_opcode,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v
);

    // Same field order as ex_entry_t: {data, rd, wb_en, opcode}.
    localparam int ENTRY_W = DATA_W + REG_W + 1 + OP_W;
    localparam logic [ENTRY_W-1:0] ENTRY_RST = {{DATA_W{1'b0}}, {REG_W{1'b0}}, 1'b0, OP_NO_OP};

    logic               accept;
    logic               is_nop;
    logic               known_op;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] out_entry;

    assign is_nop   = (opcode == OP_NO_OP);
    assign known_op = is_alu_op(opcode);
    assign accept   = in_valid && in_ready && !flush;

    // The ALU leaves its result undriven for unknown opcodes, so such entries
    // travel on as harmless bubbles: zero data, no writeback.
    assign in_entry = known_op ? {alu_out, rd, wb_en, opcode}
                               : {{DATA_W{1'b0}}, rd, 1'b0, opcode};

    // NO_OP completes the handshake but never occupies a slot.
    ex_skid_buf #(
        .W       (ENTRY_W),
        .RST_VAL (ENTRY_RST)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid && !is_nop),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign {out_data, out_rd, out_wb_en, out_opcode} = out_entry;

    // Flags commit at accept time, not at MEM handoff, so they always track
    // the youngest flag-setting instruction regardless of backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else if (accept && alu_done && known_op) begin
            flag_n <= alu_n;
            flag_z <= alu_z;
            flag_v <= alu_v;
        end
    end

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;
    import ex_result_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        alu_n, alu_z, alu_v, alu_done;
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic        wb_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic [5:0]  out_opcode;
    logic        flag_n, flag_z, flag_v;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;

    logic [43:0] exp_q[$];
    logic [2:0]  m_flags = 3'b000;
    logic        stalled = 1'b0;
    logic [43:0] held;

    ex_result_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .alu_done(alu_done), .opcode(opcode), .rd(rd), .wb_en(wb_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .out_opcode(out_opcode),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard / reference model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [43:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_flags = 3'b000;
            stalled = 1'b0;
        end else begin
            chk("flags", {flag_n, flag_z, flag_v}, m_flags);
            if (stalled) chk("hold", {out_data, out_rd, out_wb_en, out_opcode}, held);
            if (flush) begin
                exp_q.delete();
                stalled = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("extra_out", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_entry", {out_data, out_rd, out_wb_en, out_opcode}, e);
                        n_pops++;
                    end
                end
                stalled = out_valid && !out_ready;
                held    = {out_data, out_rd, out_wb_en, out_opcode};
                if (in_valid && in_ready && opcode != 6'h3F) begin
                    if (opcode >= 6'h20 && opcode <= 6'h28) begin
                        exp_q.push_back({alu_out, rd, wb_en, opcode});
                        if (alu_done) m_flags = {alu_n, alu_z, alu_v};
                    end else begin
                        exp_q.push_back({32'h0, rd, 1'b0, opcode});
                    end
                end
            end
        end
    end

    task automatic set_in(input logic [5:0] op, input logic [31:0] d, input logic [4:0] r,
                          input logic w, input logic dn, input logic [2:0] nzv);
        in_valid = 1'b1;
        opcode   = op;
        alu_out  = d;
        rd       = r;
        wb_en    = w;
        alu_done = dn;
        {alu_n, alu_z, alu_v} = nzv;
    endtask

    // Present one instruction and hold it until the stage accepts it.
    task automatic send(input logic [5:0] op, input logic [31:0] d, input logic [4:0] r,
                        input logic w, input logic dn, input logic [2:0] nzv);
        bit ok = 0;
        set_in(op, d, r, w, dn, nzv);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; alu_out = '0; alu_n = 0; alu_z = 0; alu_v = 0;
        alu_done = 0; opcode = 6'h3F; rd = '0; wb_en = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_wb_en", out_wb_en, 0);
        chk("rst_out_opcode", out_opcode, 6'h3F);
        chk("rst_flags", {flag_n, flag_z, flag_v}, 3'b000);
        #8 rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with zero result
        send(OP_ADD, 32'h0, 5'd3, 1, 1, 3'b010);
        chk("add_out_valid", out_valid, 1);
        chk("add_out_data", out_data, 32'h0);
        chk("add_out_rd", out_rd, 5'd3);
        chk("add_flags", {flag_n, flag_z, flag_v}, 3'b010);

        // SUB sets N,V; SLL must not disturb them
        send(OP_SUB, 32'h8000_0005, 5'd4, 1, 1, 3'b101);
        send(OP_SLL, 32'h10, 5'd5, 1, 0, 3'b010);
        chk("sll_out_data", out_data, 32'h10);
        chk("sll_flags", {flag_n, flag_z, flag_v}, 3'b101);
        idle(2);

        // Backpressure: A, B fill the buffer, C waits
        out_ready = 1'b0;
        send(OP_AND, 32'hAAAA_0001, 5'd6, 1, 1, 3'b000);
        send(OP_XOR, 32'hBBBB_0002, 5'd7, 1, 1, 3'b100);
        set_in(OP_ADDI, 32'hCCCC_0003, 5'd8, 1, 1, 3'b001);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        idle(2);
        chk("full_stall_data", out_data, 32'hAAAA_0001);
        out_ready = 1'b1;
        send(OP_ADDI, 32'hCCCC_0003, 5'd8, 1, 1, 3'b001);
        idle(3);
        chk("drain_empty", out_valid, 0);

        // Unknown opcode travels as a bubble, flags untouched
        send(6'h10, 32'hDEAD_BEEF, 5'd9, 1, 1, 3'b111);
        idle(2);
        chk("unk_flags", {flag_n, flag_z, flag_v}, 3'b001);

        // Flush on a full buffer with a flag-setting XOR presented
        out_ready = 1'b0;
        send(OP_NAND, 32'h1111_1111, 5'd10, 1, 1, 3'b000);
        send(OP_ANDI, 32'h2222_2222, 5'd11, 1, 1, 3'b000);
        set_in(OP_XOR, 32'h0, 5'd12, 1, 1, 3'b010);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_flag_z", flag_z, 0);
        // Flush from empty also blocks the accept
        set_in(OP_XOR, 32'h5, 5'd12, 1, 1, 3'b010);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_out_valid", out_valid, 0);
        chk("flush2_flag_z", flag_z, 0);
        out_ready = 1'b1;
        idle(1);

        // NO_OP between two ADDs
        p0 = n_pops;
        send(OP_ADD, 32'h0000_0042, 5'd1, 1, 1, 3'b100);
        send(OP_NO_OP, 32'h1234_5678, 5'd2, 1, 1, 3'b111);
        send(OP_ADD, 32'h0000_0000, 5'd3, 1, 1, 3'b011);
        idle(3);
        chk("nop_pop_count", n_pops - p0, 2);
        chk("nop_flags", {flag_n, flag_z, flag_v}, 3'b011);

        // Async reset mid-cycle while FULL
        out_ready = 1'b0;
        send(OP_SRL, 32'h7, 5'd13, 1, 0, 3'b000);
        send(OP_SUB, 32'h9, 5'd14, 1, 1, 3'b101);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_flags", {flag_n, flag_z, flag_v}, 3'b000);
        chk("arst_out_opcode", out_opcode, 6'h3F);
        @(negedge clk); #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(OP_ADD, 32'hFFFF_FFFF, 5'd15, 1, 1, 3'b100);
        idle(3);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
